// File: rtl/vic_arbiter.sv
// vic_arbiter: vectored interrupt responder for the CPU interrupt vector bus.
//
// Collects level-sensitive requests from NREQ channels, raises virq toward the
// CPU, and answers each istb strobe with the winning channel's 16-bit vector on
// ivec together with iack. The winning channel gets a one-cycle dev_ack pulse
// so the device can clear its request. Channel 0 has the highest priority.
//
// Ports:
//   clk_p    system clock, rising edge
//   rst      synchronous active-high reset
//   dev_req  per-channel request level (NREQ)
//   dev_vec  per-channel vectors, channel k at [16k+15:16k]
//   dev_ack  per-channel one-cycle acknowledge pulse (one-hot or zero)
//   virq     interrupt request to the CPU
//   istb     vector-read strobe from the CPU
//   ivec     vector to the CPU, zero when not acknowledging
//   iack     vector acknowledge to the CPU
//
// All outputs are registered; nothing passes combinationally from an input to
// an output.
module vic_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [15:0] STRAY_VEC = 16'o000000
) (
    input  logic                 clk_p,
    input  logic                 rst,
    input  logic [NREQ-1:0]      dev_req,
    input  logic [16*NREQ-1:0]   dev_vec,
    output logic [NREQ-1:0]      dev_ack,
    output logic                 virq,
    input  logic                 istb,
    output logic [15:0]          ivec,
    output logic                 iack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            virq_q, virq_d;
    logic            iack_q, iack_d;
    logic [15:0]     ivec_q, ivec_d;
    logic [NREQ-1:0] dev_ack_q, dev_ack_d;
    // Set once istb has been seen low since reset; a strobe that is still
    // high coming out of reset is not answered.
    logic            seen_low_q, seen_low_d;

    logic            any;
    logic            found;
    logic [NREQ-1:0] win_oh;
    logic [15:0]     win_vec;
    logic            strobe;

    // Fixed-priority pick: lowest index wins. With no request the vector
    // falls back to STRAY_VEC and the one-hot is empty, so a stray strobe
    // produces no dev_ack.
    always_comb begin
        any     = |dev_req;
        found   = 1'b0;
        win_oh  = '0;
        win_vec = STRAY_VEC;
        for (int k = 0; k < NREQ; k++) begin
            if (dev_req[k] && !found) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
                win_vec   = dev_vec[16*k +: 16];
            end
        end
    end

    assign strobe = istb & seen_low_q;

    always_comb begin
        state_d    = state_q;
        virq_d     = virq_q;
        iack_d     = iack_q;
        ivec_d     = ivec_q;
        dev_ack_d  = '0;
        seen_low_d = seen_low_q | ~istb;
        case (state_q)
            // A strobe in IDLE is treated exactly like one in PEND so the CPU
            // always gets an answer to its vector read.
            S_IDLE, S_PEND: begin
                if (strobe) begin
                    state_d   = S_ACK;
                    virq_d    = 1'b0;
                    iack_d    = 1'b1;
                    ivec_d    = win_vec;   // frozen for the whole ACK phase
                    dev_ack_d = win_oh;
                end else if (any) begin
                    state_d = S_PEND;
                    virq_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    virq_d  = 1'b0;
                end
            end
            S_ACK: begin
                virq_d = 1'b0;
                if (!istb) begin
                    state_d = S_GAP;
                    iack_d  = 1'b0;
                    ivec_d  = '0;
                end
            end
            // One quiet cycle so the acknowledged device can drop its request
            // before it is arbitrated again.
            S_GAP: begin
                state_d = S_IDLE;
                virq_d  = 1'b0;
                iack_d  = 1'b0;
                ivec_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                virq_d  = 1'b0;
                iack_d  = 1'b0;
                ivec_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            state_q    <= S_IDLE;
            virq_q     <= 1'b0;
            iack_q     <= 1'b0;
            ivec_q     <= '0;
            dev_ack_q  <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            virq_q     <= virq_d;
            iack_q     <= iack_d;
            ivec_q     <= ivec_d;
            dev_ack_q  <= dev_ack_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign virq    = virq_q;
    assign iack    = iack_q;
    assign ivec    = ivec_q;
    assign dev_ack = dev_ack_q;

endmodule
